// File: rtl/mem_pkg.sv
// Shared types and defaults for the main-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } mem_state_t;

  localparam int MEM_DEFAULT_WAIT  = 4;
  localparam int MEM_DEFAULT_DEPTH = 256;

endpackage

// File: rtl/mem_wait_ctr.sv
// 8-bit loadable down-counter. It flags the last wait state, or an immediate
// response when it is loaded with zero.
module mem_wait_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign done = load ? (load_val == 8'd0) : (count == 8'd1);

endmodule

// File: rtl/main_mem_responder.sv
// Slow main-memory model for the cache strobe interface: one request at a time,
// a fixed number of wait states, then a one-cycle MReady response.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = MEM_DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = MEM_DEFAULT_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MReady,
  output logic              MBusy,
  output logic              MErr,
  output logic              MOverrun
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  mem_state_t        state;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              ctr_load;
  logic              ctr_done;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] port_addr;
  logic [IDX_W-1:0]  port_idx;
  logic              port_ok;
  logic              resp_rw;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  // Single array port: the live request address while IDLE (WAIT_CYCLES=0 case),
  // the captured one otherwise. Reads happen entering RESPOND, writes leaving it.
  assign port_addr = (state == IDLE) ? MAddr : req_addr;
  assign resp_rw   = (state == IDLE) ? MRW   : req_rw;
  assign port_idx  = port_addr[IDX_W-1:0];
  assign port_ok   = {1'b0, port_addr} < DEPTH_EXT;
  assign mem_rd    = mem[port_idx];
  assign mem_we    = (state == RESPOND) && req_rw && port_ok;
  assign ctr_load  = (state == IDLE) && MStrobe;

  mem_wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (ctr_load),
    .load_val (8'(WAIT_CYCLES)),
    .done     (ctr_done)
  );

  // NOTE: the array has no reset; its contents must survive a reset, and a
  // reset-free block lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[port_idx] <= req_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req_rw   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      MDataOut <= '0;
      MReady   <= 1'b0;
      MBusy    <= 1'b0;
      MErr     <= 1'b0;
      MOverrun <= 1'b0;
    end else begin
      MReady <= 1'b0;
      case (state)
        IDLE: begin
          if (MStrobe) begin
            req_rw   <= MRW;
            req_addr <= MAddr;
            req_data <= MDataIn;
            MBusy    <= 1'b1;
            state    <= ctr_done ? RESPOND : WAIT;
          end
        end
        WAIT: begin
          if (MStrobe) MOverrun <= 1'b1;
          if (ctr_done) state <= RESPOND;
        end
        RESPOND: begin
          if (MStrobe) MOverrun <= 1'b1;
          state <= IDLE;
          MBusy <= 1'b0;
          MErr  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Response outputs are registered on the edge that enters RESPOND.
      if (ctr_done && (ctr_load || state == WAIT)) begin
        MReady <= 1'b1;
        MErr   <= !port_ok;
        if (!resp_rw) MDataOut <= port_ok ? mem_rd : '0;
      end
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench: default build (4 wait states) as dut_a, WAIT_CYCLES=0 build as dut_b.
module tb_main_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        a_strobe = 1'b0, a_rw = 1'b0;
  logic [15:0] a_addr = '0;
  logic [31:0] a_din = '0, a_dout;
  logic        a_ready, a_busy, a_err, a_ovr;

  logic        b_strobe = 1'b0, b_rw = 1'b0;
  logic [15:0] b_addr = '0;
  logic [31:0] b_din = '0, b_dout;
  logic        b_ready, b_busy, b_err, b_ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_mem_responder dut_a (
    .clk(clk), .reset(reset), .MStrobe(a_strobe), .MRW(a_rw), .MAddr(a_addr),
    .MDataIn(a_din), .MDataOut(a_dout), .MReady(a_ready), .MBusy(a_busy),
    .MErr(a_err), .MOverrun(a_ovr)
  );

  main_mem_responder #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .MStrobe(b_strobe), .MRW(b_rw), .MAddr(b_addr),
    .MDataIn(b_din), .MDataOut(b_dout), .MReady(b_ready), .MBusy(b_busy),
    .MErr(b_err), .MOverrun(b_ovr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; returns the cycle (1 = cycle after the strobe edge) in
  // which MReady is seen, or -1 on timeout. Leaves time in the MReady cycle.
  task automatic do_req(input bit sel, input logic rw, input logic [15:0] addr,
                        input logic [31:0] data, output int lat);
    lat = -1;
    if (sel) begin b_strobe = 1'b1; b_rw = rw; b_addr = addr; b_din = data; end
    else     begin a_strobe = 1'b1; a_rw = rw; a_addr = addr; a_din = data; end
    tick();
    a_strobe = 1'b0;
    b_strobe = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if ((sel ? b_ready : a_ready) === 1'b1) begin
        lat = n;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({a_ready, a_busy, a_err, a_ovr} !== 4'b0 || a_dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy/busy/err/ovr=%b dout=%h, want 0000 and 0",
               {a_ready, a_busy, a_err, a_ovr}, a_dout);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int lat;
    do_req(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL write_latency: got %0d want 5", lat); end
    checks++;
    if (a_err !== 1'b0 || a_dout !== 32'h0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL write_resp: err=%b dout=%h busy=%b, want 0 0 1", a_err, a_dout, a_busy);
    end
    tick();
    checks++;
    if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL write_end: ready=%b busy=%b, want 0 0", a_ready, a_busy);
    end
  endtask

  task automatic test_read_back();
    int lat;
    do_req(1'b0, 1'b0, 16'h0010, 32'h0, lat);
    checks++;
    if (lat !== 5 || a_dout !== 32'hDEADBEEF || a_err !== 1'b0) begin
      errors++;
      $display("FAIL read_back: lat=%0d dout=%h err=%b, want 5 deadbeef 0", lat, a_dout, a_err);
    end
    tick();
    checks++;
    if (a_dout !== 32'hDEADBEEF) begin
      errors++; $display("FAIL dout_hold: got %h want deadbeef", a_dout);
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    do_req(1'b0, 1'b1, 16'h0100, 32'h12345678, lat);
    checks++;
    if (lat !== 5 || a_err !== 1'b1 || a_dout !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL oor_write: lat=%0d err=%b dout=%h, want 5 1 deadbeef", lat, a_err, a_dout);
    end
    tick();
    do_req(1'b0, 1'b0, 16'h0100, 32'h0, lat);
    checks++;
    if (lat !== 5 || a_err !== 1'b1 || a_dout !== 32'h0) begin
      errors++;
      $display("FAIL oor_read: lat=%0d err=%b dout=%h, want 5 1 0", lat, a_err, a_dout);
    end
    tick();
    checks++;
    if (a_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", a_err); end
    do_req(1'b0, 1'b0, 16'h00FF, 32'h0, lat);
    checks++;
    if (lat !== 5 || a_err !== 1'b0) begin
      errors++; $display("FAIL last_word: lat=%0d err=%b, want 5 0", lat, a_err);
    end
    tick();
  endtask

  task automatic test_overrun();
    int pulses = 0;
    a_strobe = 1'b1; a_rw = 1'b0; a_addr = 16'h0010;
    tick();                                   // edge 0: read accepted
    a_strobe = 1'b0;
    tick(); tick();                           // cycle 3
    a_strobe = 1'b1; a_rw = 1'b1; a_din = 32'h0BADF00D;
    tick();                                   // edge 3: strobe while busy
    a_strobe = 1'b0;
    checks++;
    if (a_ovr !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", a_ovr); end
    for (int n = 0; n < 15; n++) begin
      if (a_ready === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", pulses); end
    do_req(1'b0, 1'b0, 16'h0010, 32'h0, pulses);
    checks++;
    if (a_dout !== 32'hDEADBEEF || a_ovr !== 1'b1) begin
      errors++;
      $display("FAIL overrun_drop: dout=%h ovr=%b, want deadbeef 1", a_dout, a_ovr);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int pulses = 0;
    do_req(1'b0, 1'b1, 16'h0020, 32'h11112222, lat);
    tick();
    a_strobe = 1'b1; a_rw = 1'b1; a_addr = 16'h0020; a_din = 32'hAAAA5555;
    tick();                                   // edge 0
    a_strobe = 1'b0;
    tick(); tick();                           // cycle 3
    reset = 1'b0;
    #1;
    checks++;
    if ({a_ready, a_busy, a_err, a_ovr} !== 4'b0 || a_dout !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset: rdy/busy/err/ovr=%b dout=%h, want 0000 and 0",
               {a_ready, a_busy, a_err, a_ovr}, a_dout);
    end
    tick();
    reset = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (a_ready === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midop_ready: got %0d want 0", pulses); end
    do_req(1'b0, 1'b0, 16'h0020, 32'h0, lat);
    checks++;
    if (lat !== 5 || a_dout !== 32'h11112222) begin
      errors++;
      $display("FAIL midop_old_data: lat=%0d dout=%h, want 5 11112222", lat, a_dout);
    end
    tick();
  endtask

  task automatic test_zero_wait();
    int lat;
    do_req(1'b1, 1'b1, 16'h0005, 32'hCAFE0001, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL zw_write_latency: got %0d want 1", lat); end
    tick();
    do_req(1'b1, 1'b1, 16'h0006, 32'hCAFE0002, lat);
    tick();
    do_req(1'b1, 1'b0, 16'h0005, 32'h0, lat);
    checks++;
    if (lat !== 1 || b_dout !== 32'hCAFE0001) begin
      errors++; $display("FAIL zw_read: lat=%0d dout=%h, want 1 cafe0001", lat, b_dout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] rdy;
    b_strobe = 1'b1; b_rw = 1'b0; b_addr = 16'h0006;
    tick();                                   // edge 0
    b_strobe = 1'b0;
    rdy[0] = b_ready;
    checks++;
    if (b_dout !== 32'hCAFE0002) begin
      errors++; $display("FAIL b2b_first: got %h want cafe0002", b_dout);
    end
    tick();
    rdy[1] = b_ready;
    b_strobe = 1'b1; b_addr = 16'h0005;
    tick();                                   // edge 2
    b_strobe = 1'b0;
    rdy[2] = b_ready;
    checks++;
    if (b_dout !== 32'hCAFE0001) begin
      errors++; $display("FAIL b2b_second: got %h want cafe0001", b_dout);
    end
    tick();
    rdy[3] = b_ready;
    checks++;
    if (rdy !== 4'b0101 || b_ovr !== 1'b0) begin
      errors++; $display("FAIL b2b_pattern: ready=%b ovr=%b, want 0101 0", rdy, b_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_back();
    test_out_of_range();
    test_overrun();
    test_reset_mid_op();
    test_zero_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
